costas_loop_sched: RTL and testbench
====================================

// Module: costas_loop_sched
// PURPOSE
//  Time-multiplexed PI loop-filter scheduler for the carrier tracking channels.
//  - Each channel posts one truncated phase-error sample per integration period.
//  - Round-robin arbitration grants one channel at a time to a single shared signed multiplier.
//  - Per channel, the block keeps the integrator, computes correction = P + I and returns it to that channel's carrier NCO.
//  - Replaces per-channel filter instances with one sequenced datapath.
// PARAMETERS
//  N_CH      4    number of tracking channels (2..16)
//  ERR_W     32   phase-error / correction / integrator width (signed)
//  GAIN_W    16   kp/ki width (signed)
//  SHIFT_KP  8    arithmetic right shift applied to err*kp
//  SHIFT_KI  8    arithmetic right shift applied to err*ki
// PORTS
//  clk         in   1               clock
//  rst         in   1               asynchronous, active-high reset
//  err_valid   in   N_CH            1-cycle strobe per channel: new error sample
//  err_data    in   N_CH*ERR_W      packed signed errors, ch i at [i*ERR_W +: ERR_W]
//  kp          in   GAIN_W          proportional gain, signed
//  ki          in   GAIN_W          integral gain, signed
//  chan_clear  in   N_CH            per-channel integrator clear (reacquire)
//  corr_valid  out  1               1-cycle strobe: corr_data/corr_ch valid
//  corr_ch     out  $clog2(N_CH)    channel index of corr_data
//  corr_data   out  ERR_W           signed saturated correction
//  busy        out  1               FSM not in IDLE
//  overrun     out  N_CH            1-cycle pulse: sample arrived while previous still pending
// BEHAVIOUR
//  Reset (async): all outputs 0, integrators 0, pending 0, RR pointer 0, FSM IDLE.
//  Capture: on err_valid[i], pend[i]<=1 and hold[i]<=err_data slice.
//    If pend[i] already set: hold overwritten with newest sample, overrun[i] pulses next cycle.
//  FSM: IDLE -> MUL_P -> MUL_I -> ACC -> OUT -> IDLE; no stalls.
//   IDLE: if any pend, grant the first pending channel at or after rr_ptr (wrapping).
//     Load work_err<=hold[g], kp_r<=kp, ki_r<=ki; clear pend[g]; rr_ptr<=g+1 mod N_CH.
//     err_valid[g] in the grant cycle re-sets pend[g] with the new sample; no overrun.
//   MUL_P: prod <= work_err*kp_r (full ERR_W+GAIN_W precision).
//   MUL_I: p_term <= sat(prod>>>SHIFT_KP); prod <= work_err*ki_r.
//   ACC: acc_new = sat(integ[g] + (prod>>>SHIFT_KI)); integ[g] <= acc_new.
//   OUT: corr_data <= sat(p_term+acc_new), corr_ch <= g, corr_valid <= 1 for one cycle.
//  Latency: err_valid sampled at edge E0 -> corr_valid high after edge E5 (idle block).
//  Throughput: one channel per 5 cycles; gains are latched at grant only.
//  Saturation: clamp to [-2^(ERR_W-1), 2^(ERR_W-1)-1] at every sat().
//  chan_clear[i] outside an active op of i: integ[i] <= 0 next edge.
//    Pending sample is kept and later filtered with integ=0.
//  chan_clear[g] during MUL_P..OUT of active channel g: op aborts.
//    integ[g]=0, no corr_valid, FSM -> IDLE next edge.
//    Clear beats the ACC write when both fall in the same cycle.
//  chan_clear and err_valid on the same channel, same cycle: both take effect.
//  Reset mid-operation: op discarded, everything returns to reset values.
// TESTING
//  T1 kp=0x0100, ki=0x0010, shifts 8, ch0 err=1600 -> corr_valid at E5, ch0, corr=1700.
//     Repeat err=1600 -> corr=1800.
//  T2 err_valid=4'b1111 same cycle, errs 100/200/300/400, kp=0x0100, ki=0 -> outputs ch0..3.
//     corr 100/200/300/400, corr_valid spaced 5 cycles; next request on ch0 served after ch3.
//  T3 integ ch1 near max: repeated err=0x7FFF_FFFF, ki=0x7FFF -> corr_data pinned at 0x7FFF_FFFF.
//     Negative mirror pinned at 0x8000_0000.
//  T4 ch2 err_valid twice before grant (errs 10 then 20) -> overrun[2] one pulse.
//     Single output computed from 20.
//  T5 chan_clear[0] during MUL_I of ch0 -> no corr_valid, integ0=0.
//     Next err=1600 -> corr=1700.
//  T6 assert rst during ACC -> all outputs 0 immediately; busy=0.
//     Pending/integrators cleared; first post-reset sample behaves as T1.

Source files
------------

// File: rtl/costas_loop_sched.sv
// Shared PI loop-filter datapath for N_CH carrier tracking channels.
// Round-robin picks one pending channel; one signed multiplier serves both gain products.
module costas_loop_sched #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned ERR_W    = 32,
  parameter int unsigned GAIN_W   = 16,
  parameter int unsigned SHIFT_KP = 8,
  parameter int unsigned SHIFT_KI = 8,
  localparam int unsigned CH_W    = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          err_valid_i,
  input  logic [N_CH*ERR_W-1:0]    err_data_i,
  input  logic signed [GAIN_W-1:0] kp_i,
  input  logic signed [GAIN_W-1:0] ki_i,
  input  logic [N_CH-1:0]          chan_clear_i,
  output logic                     corr_valid_o,
  output logic [CH_W-1:0]          corr_ch_o,
  output logic signed [ERR_W-1:0]  corr_data_o,
  output logic                     busy_o,
  output logic [N_CH-1:0]          overrun_o
);

  localparam int unsigned ProdW = ERR_W + GAIN_W;
  localparam int unsigned WideW = ProdW + 1;
  localparam logic signed [WideW-1:0] SatMax = {{(WideW-ERR_W+1){1'b0}}, {(ERR_W-1){1'b1}}};
  localparam logic signed [WideW-1:0] SatMin = {{(WideW-ERR_W+1){1'b1}}, {(ERR_W-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StMulP, StMulI, StAcc, StOut} state_e;

  function automatic logic [CH_W-1:0] wrap_inc(input logic [CH_W-1:0] a, input int unsigned b);
    return CH_W'((32'(a) + b) % N_CH);
  endfunction

  function automatic logic signed [WideW-1:0] ext_e(input logic signed [ERR_W-1:0] v);
    return $signed({{(WideW-ERR_W){v[ERR_W-1]}}, v});
  endfunction

  function automatic logic signed [WideW-1:0] ext_p(input logic signed [ProdW-1:0] v);
    return $signed({{(WideW-ProdW){v[ProdW-1]}}, v});
  endfunction

  function automatic logic signed [ERR_W-1:0] sat(input logic signed [WideW-1:0] v);
    if (v > SatMax) return SatMax[ERR_W-1:0];
    if (v < SatMin) return SatMin[ERR_W-1:0];
    return v[ERR_W-1:0];
  endfunction

  state_e                   state_q, state_d;
  logic [N_CH-1:0]          pend_q, pend_d;
  logic [N_CH-1:0]          overrun_q, overrun_d;
  logic [N_CH-1:0]          grant_mask;
  logic signed [ERR_W-1:0]  hold_q  [N_CH];
  logic signed [ERR_W-1:0]  integ_q [N_CH];
  logic [CH_W-1:0]          rr_ptr_q, cur_ch_q, grant_ch;
  logic                     grant_vld, grant_fire, abort;
  logic signed [ERR_W-1:0]  work_err_q, p_term_q, acc_q, acc_new, p_sat;
  logic signed [GAIN_W-1:0] kp_q, ki_q;
  logic signed [ProdW-1:0]  prod_q, mul_a, mul_b, mul_res;
  logic                     corr_valid_q;
  logic [CH_W-1:0]          corr_ch_q;
  logic signed [ERR_W-1:0]  corr_data_q;

  // First pending channel at or after the round-robin pointer.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (!grant_vld && pend_q[wrap_inc(rr_ptr_q, k)]) begin
        grant_vld = 1'b1;
        grant_ch  = wrap_inc(rr_ptr_q, k);
      end
    end
  end

  assign grant_fire = (state_q == StIdle) && grant_vld;
  assign abort      = (state_q != StIdle) && chan_clear_i[cur_ch_q];

  always_comb begin
    grant_mask = '0;
    if (grant_fire) grant_mask[grant_ch] = 1'b1;
    pend_d    = (pend_q & ~grant_mask) | err_valid_i;
    overrun_d = err_valid_i & pend_q & ~grant_mask;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant_vld) state_d = StMulP;
      StMulP:  state_d = StMulI;
      StMulI:  state_d = StAcc;
      StAcc:   state_d = StOut;
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort) state_d = StIdle;
  end

  // One multiplier: kp in MUL_P, ki in MUL_I.
  assign mul_a   = $signed({{GAIN_W{work_err_q[ERR_W-1]}}, work_err_q});
  assign mul_b   = (state_q == StMulP) ? $signed({{ERR_W{kp_q[GAIN_W-1]}}, kp_q})
                                       : $signed({{ERR_W{ki_q[GAIN_W-1]}}, ki_q});
  assign mul_res = mul_a * mul_b;
  assign p_sat   = sat(ext_p(prod_q >>> SHIFT_KP));
  assign acc_new = sat(ext_e(integ_q[cur_ch_q]) + ext_p(prod_q >>> SHIFT_KI));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q       <= '0;
      overrun_q    <= '0;
      rr_ptr_q     <= '0;
      cur_ch_q     <= '0;
      work_err_q   <= '0;
      kp_q         <= '0;
      ki_q         <= '0;
      prod_q       <= '0;
      p_term_q     <= '0;
      acc_q        <= '0;
      corr_valid_q <= 1'b0;
      corr_ch_q    <= '0;
      corr_data_q  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        hold_q[i]  <= '0;
        integ_q[i] <= '0;
      end
    end else begin
      pend_q       <= pend_d;
      overrun_q    <= overrun_d;
      corr_valid_q <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        if (err_valid_i[i]) hold_q[i] <= err_data_i[i*ERR_W +: ERR_W];
        // Clear wins over the ACC write-back of the same channel.
        if (chan_clear_i[i])                                    integ_q[i] <= '0;
        else if (state_q == StAcc && cur_ch_q == CH_W'(i))      integ_q[i] <= acc_new;
      end
      if (grant_fire) begin
        work_err_q <= hold_q[grant_ch];
        kp_q       <= kp_i;
        ki_q       <= ki_i;
        cur_ch_q   <= grant_ch;
        rr_ptr_q   <= wrap_inc(grant_ch, 1);
      end
      case (state_q)
        StMulP: prod_q <= mul_res;
        StMulI: begin
          p_term_q <= p_sat;
          prod_q   <= mul_res;
        end
        StAcc:  acc_q <= acc_new;
        StOut: begin
          if (!abort) begin
            corr_valid_q <= 1'b1;
            corr_ch_q    <= cur_ch_q;
            corr_data_q  <= sat(ext_e(p_term_q) + ext_e(acc_q));
          end
        end
        default: ;
      endcase
    end
  end

  assign corr_valid_o = corr_valid_q;
  assign corr_ch_o    = corr_ch_q;
  assign corr_data_o  = corr_data_q;
  assign busy_o       = (state_q != StIdle);
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_costas_loop_sched.sv
// Bench for costas_loop_sched: directed scenarios plus random traffic against a
// transaction-level PI filter model.
module tb_costas_loop_sched;
  localparam int N  = 4;
  localparam int EW = 32;
  localparam int GW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         ev, clr, overrun;
  logic [N*EW-1:0]      ed;
  logic signed [GW-1:0] kp, ki;
  logic                 corr_valid, busy;
  logic [1:0]           corr_ch;
  logic [EW-1:0]        corr_data;

  always #5 clk = ~clk;

  costas_loop_sched #(.N_CH(N), .ERR_W(EW), .GAIN_W(GW), .SHIFT_KP(8), .SHIFT_KI(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .err_valid_i  (ev),
    .err_data_i   (ed),
    .kp_i         (kp),
    .ki_i         (ki),
    .chan_clear_i (clr),
    .corr_valid_o (corr_valid),
    .corr_ch_o    (corr_ch),
    .corr_data_o  (corr_data),
    .busy_o       (busy),
    .overrun_o    (overrun)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Model state: per-channel pending sample and integrator, plus the op in flight.
  longint m_integ [N];
  longint m_hold  [N];
  bit     m_pend  [N];
  int     m_rr, m_left, m_ch;
  longint m_res;
  bit     m_valid;
  int     m_och;
  longint m_odata;
  bit [N-1:0] m_over;

  int     obs_ch[$];
  longint obs_data[$];
  int     obs_cyc[$];
  int     ov_cnt[N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint sat(input longint v);
    if (v > 64'sd2147483647)  return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_integ[i] = 0; m_hold[i] = 0; m_pend[i] = 0;
    end
    m_rr = 0; m_left = 0; m_ch = 0; m_res = 0;
    m_valid = 0; m_och = 0; m_odata = 0; m_over = '0;
  endtask

  task automatic model_edge();
    int g;
    longint err, p, acc;
    logic [EW-1:0] sl;
    g = -1;
    m_valid = 0;
    m_over  = '0;
    if (m_left > 0) begin
      if (clr[m_ch]) m_left = 0;
      else begin
        m_left--;
        if (m_left == 0) begin
          m_valid = 1; m_och = m_ch; m_odata = m_res;
        end
      end
    end else begin
      for (int k = 0; k < N; k++)
        if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
    end
    for (int i = 0; i < N; i++) if (clr[i]) m_integ[i] = 0;
    if (g >= 0) begin
      err = m_hold[g];
      p   = sat((err * longint'(kp)) >>> 8);
      acc = sat(m_integ[g] + ((err * longint'(ki)) >>> 8));
      m_integ[g] = acc;
      m_res  = sat(p + acc);
      m_left = 4;
      m_ch   = g;
      m_rr   = (g + 1) % N;
      m_pend[g] = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (ev[i]) begin
        m_over[i] = m_pend[i];
        m_pend[i] = 1;
        sl = ed[i*EW +: EW];
        m_hold[i] = longint'($signed(sl));
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check("corr_valid", 64'(corr_valid), 64'(m_valid));
    check("busy", 64'(busy), 64'(m_left > 0));
    check("overrun", 64'(overrun), 64'(m_over));
    check("corr_ch", 64'(corr_ch), 64'(m_och));
    check("corr_data", 64'(corr_data), 64'(m_odata[31:0]));
    if (corr_valid) begin
      obs_ch.push_back(int'(corr_ch));
      obs_data.push_back(longint'($signed(corr_data)));
      obs_cyc.push_back(cyc);
    end
    for (int i = 0; i < N; i++) ov_cnt[i] += int'(overrun[i]);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic idle();
    ev = '0; clr = '0;
  endtask

  task automatic post(input int ch, input logic [EW-1:0] err);
    ev[ch] = 1'b1;
    ed[ch*EW +: EW] = err;
  endtask

  task automatic clear_obs();
    obs_ch.delete(); obs_data.delete(); obs_cyc.delete();
    for (int i = 0; i < N; i++) ov_cnt[i] = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(corr_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_data", 64'(corr_data), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    rst = 1'b0;
    run(1);
  endtask

  // Single request on an idle block: nothing for 4 edges, result on the 5th.
  task automatic serve(input string tag, input int ch, input logic [EW-1:0] err,
                       input logic [EW-1:0] exp);
    post(ch, err);
    cycle();
    idle();
    clear_obs();
    run(4);
    check({tag, "_early"}, 64'(obs_ch.size()), 64'd0);
    run(1);
    check({tag, "_count"}, 64'(obs_ch.size()), 64'd1);
    if (obs_ch.size() > 0) begin
      check({tag, "_ch"}, 64'(obs_ch[0]), 64'(ch));
      check({tag, "_data"}, 64'(obs_data[0][31:0]), 64'(exp));
    end
  endtask

  int start;
  int mode, v;
  int exp_ch[5]   = '{0, 1, 2, 3, 0};
  int exp_dat[5]  = '{100, 200, 300, 400, 500};

  initial begin
    ev = '0; clr = '0; ed = '0; kp = '0; ki = '0; rst = 1'b1;

    // T1: basic PI result and integrator accumulation.
    do_reset();
    kp = 16'h0100; ki = 16'h0010;
    serve("t1a", 0, 32'd1600, 32'd1700);
    serve("t1b", 0, 32'd1600, 32'd1800);

    // T2: simultaneous requests served in round-robin order, 5 cycles apart.
    do_reset();
    kp = 16'h0100; ki = 16'h0000;
    post(0, 32'd100); post(1, 32'd200); post(2, 32'd300); post(3, 32'd400);
    cycle();
    start = cyc;
    idle();
    clear_obs();
    run(2);
    post(0, 32'd500);
    cycle();
    idle();
    run(30);
    check("t2_count", 64'(obs_ch.size()), 64'd5);
    if (obs_ch.size() == 5) begin
      check("t2_first_lat", 64'(obs_cyc[0] - start), 64'd5);
      for (int i = 0; i < 5; i++) begin
        check("t2_ch", 64'(obs_ch[i]), 64'(exp_ch[i]));
        check("t2_data", 64'(obs_data[i]), 64'(exp_dat[i]));
        if (i > 0) check("t2_spacing", 64'(obs_cyc[i] - obs_cyc[i-1]), 64'd5);
      end
    end

    // T3: saturation at both rails.
    do_reset();
    kp = 16'h0100; ki = 16'h7FFF;
    for (int i = 0; i < 3; i++) serve("t3_pos", 1, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    for (int i = 0; i < 3; i++) serve("t3_neg", 1, 32'h8000_0000, 32'h8000_0000);

    // T4: two samples on ch2 before its grant -> one overrun, newest sample used.
    do_reset();
    kp = 16'h0100; ki = 16'h0000;
    clear_obs();
    post(0, 32'd50);
    cycle();
    idle();
    cycle();
    post(2, 32'd10);
    cycle();
    post(2, 32'd20);
    cycle();
    idle();
    run(20);
    check("t4_overrun", 64'(ov_cnt[2]), 64'd1);
    check("t4_count", 64'(obs_ch.size()), 64'd2);
    if (obs_ch.size() == 2) begin
      check("t4_ch", 64'(obs_ch[1]), 64'd2);
      check("t4_data", 64'(obs_data[1]), 64'd20);
    end

    // T5: clear during MUL_I aborts the op and zeroes the integrator.
    do_reset();
    kp = 16'h0100; ki = 16'h0010;
    serve("t5_pre", 0, 32'd1600, 32'd1700);
    post(0, 32'd1600);
    cycle();
    idle();
    clear_obs();
    run(2);
    clr[0] = 1'b1;
    cycle();
    clr = '0;
    check("t5_busy", 64'(busy), 64'd0);
    run(8);
    check("t5_none", 64'(obs_ch.size()), 64'd0);
    serve("t5_post", 0, 32'd1600, 32'd1700);

    // T6: reset during ACC with another channel pending.
    do_reset();
    kp = 16'h0100; ki = 16'h0010;
    serve("t6_pre", 0, 32'd1600, 32'd1700);
    post(0, 32'd1600);
    cycle();
    idle();
    run(2);
    post(1, 32'd77);
    cycle();
    idle();
    #1;
    rst = 1'b1;
    #1;
    check("t6_valid", 64'(corr_valid), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_data", 64'(corr_data), 64'd0);
    check("t6_overrun", 64'(overrun), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_obs();
    run(10);
    check("t6_no_pending", 64'(obs_ch.size()), 64'd0);
    serve("t6_post", 0, 32'd1600, 32'd1700);

    // Random traffic against the model.
    do_reset();
    kp = 16'h0100; ki = 16'h0010;
    for (int c = 0; c < 800; c++) begin
      if (c % 50 == 0) begin
        kp = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 1024)) - 512);
        ki = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 256)) - 128);
      end
      for (int i = 0; i < N; i++) begin
        ev[i]  = ($urandom_range(0, 7) == 0);
        clr[i] = ($urandom_range(0, 49) == 0);
        mode = int'($urandom_range(0, 3));
        v = int'($urandom_range(0, 4000)) - 2000;
        case (mode)
          0: ed[i*EW +: EW] = 32'(v);
          1: ed[i*EW +: EW] = $urandom;
          2: ed[i*EW +: EW] = 32'h7FFF_FFFF;
          default: ed[i*EW +: EW] = 32'h8000_0000;
        endcase
      end
      cycle();
    end
    idle();
    run(10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
